gray_binary_conv_arbiter: RTL

- Shares one bit-serial Gray-to-binary conversion engine between two requesters.
- Round-robin arbiter, valid/ready handshake on both inputs and on the output.
- Sequencing FSM: accept one Gray word, resolve one binary bit per clock MSB-first, hold the result until the consumer takes it.
- Sits between Gray-coded sources (e.g. position encoders, async FIFO pointers) and binary-domain logic.

---
 rtl/gray_binary_conv_arbiter.sv | 91 +++++++++
 1 files changed

// File: rtl/gray_binary_conv_arbiter.sv
// Two-requester round-robin front end for a shared bit-serial Gray-to-binary engine.
// Accepts one Gray word and resolves one binary bit per clock, MSB first, then holds the result for the consumer.
module gray_binary_conv_arbiter #(
    parameter int WIDTH = 4,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_gray,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_gray,
    output logic             req1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_bin,
    output logic             out_id,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t           state;
    logic             ptr;
    logic [WIDTH-1:0] gray_reg;
    logic [CW-1:0]    cnt;
    logic             prev_bit;
    logic             grant1;
    logic             accept;
    logic             next_bit;

    // req1 wins when it is the only requester or when the pointer favours it
    always_comb begin
        grant1   = req1_valid && (!req0_valid || ptr);
        accept   = req0_ready || req1_ready;
        next_bit = prev_bit ^ gray_reg[cnt];
    end

    assign req0_ready = rst_n && (state == IDLE) && req0_valid && !grant1;
    assign req1_ready = rst_n && (state == IDLE) && grant1;
    assign out_valid  = (state == DONE);
    assign busy       = (state != IDLE);

    // prev_bit carries the last resolved binary bit; clearing it on acceptance makes the MSB a plain copy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= 1'b0;
            gray_reg <= '0;
            out_bin  <= '0;
            out_id   <= 1'b0;
            cnt      <= '0;
            prev_bit <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        gray_reg <= grant1 ? req1_gray : req0_gray;
                        out_id   <= grant1;
                        out_bin  <= '0;
                        cnt      <= CW'(WIDTH - 1);
                        prev_bit <= 1'b0;
                        ptr      <= ~grant1;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    out_bin[cnt] <= next_bit;
                    prev_bit     <= next_bit;
                    if (cnt == '0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
